// File: rtl/eos_sched_ctrl.sv
// Egress scheduler: grants one descriptor at a time from four metadata queues under
// time-slot gating, a q2 token-bucket rate limit and per-port FIFO backpressure.
module eos_sched_ctrl #(
    parameter logic [7:0]  USEDW_TH     = 8'd200,
    parameter int          TOKEN_PERIOD = 128,
    parameter logic [31:0] BUCKET_MAX   = 32'd4096,
    parameter logic [15:0] PKT_TIMEOUT  = 16'd4000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  q_empty,
    input  logic [83:0] q_head_md,
    output logic [3:0]  q_rd,
    input  logic        in_time_slot_flag,
    input  logic [31:0] in_rate_limit,
    input  logic [7:0]  pktout_usedw_0,
    input  logic [7:0]  pktout_usedw_1,
    input  logic        in_pkt_valid,
    output logic [7:0]  out_md,
    output logic        out_md_port,
    output logic        out_md_wr,
    output logic [63:0] out_mdout_cnt,
    output logic [15:0] out_timeout_cnt,
    output logic        out_busy
);
    localparam int RW = (TOKEN_PERIOD > 1) ? $clog2(TOKEN_PERIOD) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [1:0]    r_grant;
    logic [7:0]    r_md;
    logic          r_port;
    logic [11:0]   r_len;
    logic [15:0]   r_timer;
    logic [63:0]   r_mdout_cnt;
    logic [15:0]   r_timeout_cnt;
    logic [31:0]   r_tokens;
    logic [RW-1:0] r_refill;

    logic [11:0]   w_len [4];
    logic [7:0]    w_id [4];
    logic [3:0]    w_port;
    logic [3:0]    w_base_ok;
    logic [3:0]    w_elig;
    logic [1:0]    w_grant;
    logic          w_timeout;
    logic          w_refill_wrap;
    logic [32:0]   w_debit;
    logic [32:0]   w_credit;
    logic [32:0]   w_sum;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_head
            assign w_len[gi]     = q_head_md[21*gi+9 +: 12];
            assign w_port[gi]    = q_head_md[21*gi+8];
            assign w_id[gi]      = q_head_md[21*gi +: 8];
            assign w_base_ok[gi] = !q_empty[gi] &&
                                   ((w_port[gi] ? pktout_usedw_1 : pktout_usedw_0) < USEDW_TH);
        end
    endgenerate

    // q0/q1 are mutually exclusive through the slot flag, so at most one is open.
    assign w_elig[0] = w_base_ok[0] && !in_time_slot_flag;
    assign w_elig[1] = w_base_ok[1] &&  in_time_slot_flag;
    assign w_elig[2] = w_base_ok[2] && (r_tokens >= {20'd0, w_len[2]});
    assign w_elig[3] = w_base_ok[3];

    always_comb begin
        w_grant = 2'd3;
        if (w_elig[0])      w_grant = 2'd0;
        else if (w_elig[1]) w_grant = 2'd1;
        else if (w_elig[2]) w_grant = 2'd2;
    end

    always_comb begin
        w_state_next = r_state;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE:  if (|w_elig) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_WAIT;
            S_WAIT: begin
                if (in_pkt_valid) begin
                    w_state_next = S_IDLE;
                end else if (r_timer == PKT_TIMEOUT - 16'd1) begin
                    w_state_next = S_IDLE;
                    w_timeout    = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bucket arithmetic is widened to 33 bits so credit on a full bucket cannot wrap.
    assign w_refill_wrap = (r_refill == RW'(TOKEN_PERIOD - 1));
    assign w_debit  = (r_state == S_ISSUE && r_grant == 2'd2) ? {21'd0, r_len} : 33'd0;
    assign w_credit = w_refill_wrap ? {1'b0, in_rate_limit} : 33'd0;
    assign w_sum    = {1'b0, r_tokens} - w_debit + w_credit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_grant       <= 2'd0;
            r_md          <= 8'd0;
            r_port        <= 1'b0;
            r_len         <= 12'd0;
            r_timer       <= 16'd0;
            r_mdout_cnt   <= 64'd0;
            r_timeout_cnt <= 16'd0;
            r_tokens      <= BUCKET_MAX;
            r_refill      <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && |w_elig) begin
                r_grant <= w_grant;
                r_md    <= w_id[w_grant];
                r_port  <= w_port[w_grant];
                r_len   <= w_len[w_grant];
            end
            r_timer <= (r_state == S_WAIT && w_state_next == S_WAIT) ? r_timer + 16'd1 : 16'd0;
            if (r_state == S_ISSUE)
                r_mdout_cnt <= r_mdout_cnt + 64'd1;
            if (w_timeout && r_timeout_cnt != 16'hFFFF)
                r_timeout_cnt <= r_timeout_cnt + 16'd1;
            r_tokens <= (w_sum > {1'b0, BUCKET_MAX}) ? BUCKET_MAX : w_sum[31:0];
            r_refill <= w_refill_wrap ? '0 : r_refill + RW'(1);
        end
    end

    assign out_md_wr       = (r_state == S_ISSUE);
    assign q_rd            = out_md_wr ? (4'b0001 << r_grant) : 4'b0000;
    assign out_busy        = (r_state != S_IDLE);
    assign out_md          = r_md;
    assign out_md_port     = r_port;
    assign out_mdout_cnt   = r_mdout_cnt;
    assign out_timeout_cnt = r_timeout_cnt;
endmodule
